serial_add_ctrl: RTL

Bit-serial addition controller. It accepts two WIDTH-bit operands through a valid/ready handshake and computes the sum one bit per clock. Each bit is added by a full adder built from two `half_adder` instances plus an OR for the carry. The result is presented through a second valid/ready handshake. It sits between an operand producer and a result consumer, and time-shares a single adder cell across all bit positions.

---
 rtl/serial_add_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. Two WIDTH-bit operands are accepted through a
//   valid/ready handshake. A single full-adder cell adds them one bit per clock,
//   LSB first. The cell is two half adders plus an OR for the carry. The result
//   is then offered through a second valid/ready handshake.
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operands a/b valid
//     in_ready   out  controller idle and able to accept operands
//     a, b       in   WIDTH-bit operands, sampled on accept
//     abort      in   cancel the addition in progress (RUN only)
//     busy       out  addition in progress
//     out_valid  out  sum/carry_out valid (DONE)
//     out_ready  in   consumer accepts the result
//     sum        out  (a+b) mod 2^WIDTH, updated only on completion
//     carry_out  out  bit WIDTH of a+b, updated only on completion
// -----------------------------------------------------------------------------

// Combinational half adder used as the building block of the serial cell.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;

  logic             w_ha1_sum;
  logic             w_ha1_carry;
  logic             w_ha2_sum;
  logic             w_ha2_carry;
  logic             w_c_nxt;
  logic [WIDTH-1:0] w_work_nxt;

  // First half adder: the two operand bits.
  half_adder u_ha1 (
    .i_a     (r_sa[0]),
    .i_b     (r_sb[0]),
    .o_sum   (w_ha1_sum),
    .o_carry (w_ha1_carry)
  );

  // Second half adder: partial sum plus the carry from the previous bit.
  half_adder u_ha2 (
    .i_a     (w_ha1_sum),
    .i_b     (r_c),
    .o_sum   (w_ha2_sum),
    .o_carry (w_ha2_carry)
  );

  assign w_c_nxt = w_ha1_carry | w_ha2_carry;

  // The new bit enters at the MSB. After WIDTH shifts, bit 0 holds the LSB result.
  assign w_work_nxt = {w_ha2_sum, r_work[WIDTH-1:1]};

  // Control FSM, datapath registers and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_work      <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sa       <= a;
            r_sb       <= b;
            r_c        <= 1'b0;
            r_cnt      <= '0;
            r_work     <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort wins over completion, even on the last bit, so sum/carry_out
          // never pick up a partial result.
          if (abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_work <= w_work_nxt;
            r_sa   <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb   <= {1'b0, r_sb[WIDTH-1:1]};
            r_c    <= w_c_nxt;
            r_cnt  <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_state     <= S_DONE;
              r_sum       <= w_work_nxt;
              r_carry     <= w_c_nxt;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry;

endmodule
